// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor table port arbiter.
package bp_pkg;

  localparam int IDX_W_DEF  = 10;
  localparam int QDEPTH_DEF = 4;
  // Queue entries carry a fixed-width index field; the arbiter uses the low IDX_W bits.
  localparam int IDX_MAX_W  = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue for resolved branches: circular buffer with full entry visibility
// so the arbiter can forward queued outcomes to lookups.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  upd_entry_t              push_entry,
  input  logic                    pop,
  output upd_entry_t              head,
  output logic [CNT_W-1:0]        count,
  output logic [PTR_W-1:0]        rd_ptr,
  output upd_entry_t [QDEPTH-1:0] entries
);

  upd_entry_t [QDEPTH-1:0] mem;
  logic [PTR_W-1:0]        wr_ptr;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/bp_port_arb.sv
// Single-port predictor table arbiter: init sweep, then fetch reads win over queued
// update writes. Define BP_ARB_FWD_EN to forward queued outcomes to matching lookups.
module bp_port_arb
  import bp_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_grant,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             tbl_read,
  output logic [IDX_W-1:0] tbl_idx,
  output logic             tbl_write,
  output logic [IDX_W-1:0] tbl_wr_idx,
  output logic             tbl_wr_outcome,
  output logic             init_busy,
  output logic [CNT_W-1:0] q_count,
  output logic             fwd_hit,
  output logic             fwd_taken,
  output arb_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] Q_FULL     = CNT_W'(QDEPTH);
  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

  arb_state_e              state, state_n;
  logic [IDX_W-1:0]        sweep_cnt, wr_idx_q;
  logic                    wr_outcome_q, wr_en, push, pop, q_has_room;
  upd_entry_t              push_entry, head;
  upd_entry_t [QDEPTH-1:0] entries;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    unused_bits;

  // Handshake: an update transfers on a rising edge where upd_valid && upd_ready;
  // upd_ready depends only on registered state, never on upd_valid.
  assign q_has_room  = q_count < Q_FULL;
  assign upd_ready   = (state == ST_RUN) && q_has_room;
  assign fetch_grant = (state == ST_RUN) && fetch_req && q_has_room;
  assign tbl_read    = fetch_grant;
  assign tbl_idx     = fetch_grant ? fetch_idx : '0;
  assign push        = upd_valid && upd_ready;
  assign push_entry  = {IDX_MAX_W'(upd_idx), upd_taken};
  assign init_busy   = (state == ST_INIT);
  assign dbg_state   = state;

  bp_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (q_count),
    .rd_ptr     (rd_ptr),
    .entries    (entries)
  );

  always_comb begin
    state_n        = state;
    wr_en          = 1'b0;
    pop            = 1'b0;
    tbl_wr_idx     = wr_idx_q;
    tbl_wr_outcome = wr_outcome_q;
    case (state)
      ST_INIT: begin
        wr_en          = 1'b1;
        tbl_wr_idx     = sweep_cnt;
        tbl_wr_outcome = 1'b0;
        if (sweep_cnt == SWEEP_LAST) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!fetch_grant && (q_count != '0)) begin
          wr_en          = 1'b1;
          pop            = 1'b1;
          tbl_wr_idx     = head.idx[IDX_W-1:0];
          tbl_wr_outcome = head.taken;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // The sweep write must stay quiet while reset is held, even though state is INIT.
  assign tbl_write = wr_en && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_INIT;
      sweep_cnt    <= '0;
      wr_idx_q     <= '0;
      wr_outcome_q <= 1'b0;
    end else begin
      state        <= state_n;
      wr_idx_q     <= tbl_wr_idx;
      wr_outcome_q <= tbl_wr_outcome;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

`ifdef BP_ARB_FWD_EN
  logic             fwd_match, fwd_val;
  logic [PTR_W-1:0] fwd_slot;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_match = 1'b0;
    fwd_val   = 1'b0;
    fwd_slot  = rd_ptr;
    for (int k = 0; k < QDEPTH; k++) begin
      fwd_slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < q_count) && (entries[fwd_slot].idx[IDX_W-1:0] == fetch_idx)) begin
        fwd_match = 1'b1;
        fwd_val   = entries[fwd_slot].taken;
      end
    end
  end

  assign fwd_hit   = fetch_grant && fwd_match;
  assign fwd_taken = fetch_grant && fwd_match && fwd_val;
`else
  assign fwd_hit   = 1'b0;
  assign fwd_taken = 1'b0;
`endif

  assign unused_bits = ^{head, entries, rd_ptr};

endmodule

// File: tb/tb_bp_port_arb.sv
// Self-checking bench for bp_port_arb: sweep, arbitration, queue order, forwarding, reset.
module tb_bp_port_arb;
  import bp_pkg::*;

  localparam int IDX_W  = 10;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = $clog2(QDEPTH + 1);
  localparam int W      = IDX_W + 1;
`ifdef BP_ARB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             fetch_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [IDX_W-1:0] fetch_idx = '0, upd_idx = '0;
  logic             fetch_grant, upd_ready, tbl_read, tbl_write, tbl_wr_outcome;
  logic             init_busy, fwd_hit, fwd_taken;
  logic [IDX_W-1:0] tbl_idx, tbl_wr_idx;
  logic [CNT_W-1:0] q_count;
  arb_state_e       dbg_state;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  bp_port_arb #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_idx      (fetch_idx),
    .fetch_grant    (fetch_grant),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .tbl_read       (tbl_read),
    .tbl_idx        (tbl_idx),
    .tbl_write      (tbl_write),
    .tbl_wr_idx     (tbl_wr_idx),
    .tbl_wr_outcome (tbl_wr_outcome),
    .init_busy      (init_busy),
    .q_count        (q_count),
    .fwd_hit        (fwd_hit),
    .fwd_taken      (fwd_taken),
    .dbg_state      (dbg_state)
  );

  // scoreboard: model of queue occupancy and arbitration, write order checked against exp_q
  always @(negedge clk) begin
    int sz;
    logic g_exp, w_exp;
    logic [W-1:0] got;
    if (mon_en) begin
      sz    = exp_q.size();
      g_exp = fetch_req && (sz < QDEPTH);
      w_exp = !g_exp && (sz > 0);
      checks++;
      if (fetch_grant !== g_exp || upd_ready !== (sz < QDEPTH) || tbl_write !== w_exp ||
          tbl_read !== g_exp || q_count !== CNT_W'(sz)) begin
        errors++;
        $display("FAIL cycle_model t=%0t grant=%b/%b ready=%b/%b write=%b/%b q_count=%0d/%0d",
                 $time, fetch_grant, g_exp, upd_ready, (sz < QDEPTH), tbl_write, w_exp, q_count, sz);
      end
      if (tbl_write) begin
        checks++;
        got = {tbl_wr_idx, tbl_wr_outcome};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_order t=%0t got=%h required=none", $time, got);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL write_order t=%0t got=%h required=%h", $time, got, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (upd_valid && (sz < QDEPTH)) exp_q.push_back({upd_idx, upd_taken});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_upd();
    upd_valid = 1'b1;
    upd_idx   = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
    upd_taken = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_req = 1'b1; fetch_idx = 10'h155; upd_valid = 1'b1;
    #2;
    checks++;
    if ({init_busy, fetch_grant, upd_ready, tbl_read, tbl_write, tbl_wr_outcome, fwd_hit, fwd_taken}
        !== 8'b1000_0000 || dbg_state !== ST_INIT) begin
      errors++;
      $display("FAIL reset_flags got=%b state=%0d required=10000000 state=0",
               {init_busy, fetch_grant, upd_ready, tbl_read, tbl_write, tbl_wr_outcome, fwd_hit, fwd_taken},
               dbg_state);
    end
    checks++;
    if (tbl_idx !== '0 || tbl_wr_idx !== '0 || q_count !== '0) begin
      errors++;
      $display("FAIL reset_values tbl_idx=%h tbl_wr_idx=%h q_count=%0d required=0 0 0",
               tbl_idx, tbl_wr_idx, q_count);
    end
  endtask

  task automatic test_sweep();
    int bad = 0;
    int first_bad = -1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      if (init_busy !== 1'b1 || tbl_write !== 1'b1 || tbl_wr_idx !== IDX_W'(i) ||
          tbl_wr_outcome !== 1'b0 || fetch_grant !== 1'b0 || upd_ready !== 1'b0 || tbl_read !== 1'b0) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    fetch_req = 1'b0; upd_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep bad_cycles=%0d first_bad=%0d required bad_cycles=0", bad, first_bad);
    end
    @(posedge clk); #2;
    checks++;
    if (init_busy !== 1'b0 || upd_ready !== 1'b1 || tbl_write !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL sweep_exit busy=%b ready=%b write=%b state=%0d required 0 1 0 1",
               init_busy, upd_ready, tbl_write, dbg_state);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_fetch_read();
    tick();
    fetch_req = 1'b1; fetch_idx = 10'h155;
    #1;
    checks++;
    if (fetch_grant !== 1'b1 || tbl_read !== 1'b1 || tbl_idx !== 10'h155 || tbl_write !== 1'b0) begin
      errors++;
      $display("FAIL fetch_read grant=%b read=%b idx=%h write=%b required 1 1 155 0",
               fetch_grant, tbl_read, tbl_idx, tbl_write);
    end
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_queue_full();
    logic [W-1:0] first = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      tick();
      fetch_req = 1'b1;
      fetch_idx = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      rand_upd();
      if (i == 0) first = {upd_idx, upd_taken};
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (q_count !== CNT_W'(QDEPTH) || upd_ready !== 1'b0 || fetch_grant !== 1'b0 || tbl_write !== 1'b1 ||
        {tbl_wr_idx, tbl_wr_outcome} !== first) begin
      errors++;
      $display("FAIL queue_full q=%0d ready=%b grant=%b write=%b data=%h required 4 0 0 1 %h",
               q_count, upd_ready, fetch_grant, tbl_write, {tbl_wr_idx, tbl_wr_outcome}, first);
    end
    tick();
    #1;
    checks++;
    if (fetch_grant !== 1'b1 || q_count !== CNT_W'(QDEPTH - 1) || tbl_write !== 1'b0) begin
      errors++;
      $display("FAIL full_regrant grant=%b q=%0d write=%b required 1 3 0", fetch_grant, q_count, tbl_write);
    end
    fetch_req = 1'b0;
    repeat (QDEPTH + 2) tick();
  endtask

  task automatic test_push_pop();
    tick(); fetch_req = 1'b1; rand_upd();
    tick(); rand_upd();
    for (int i = 0; i < 10; i++) begin
      tick();
      fetch_req = 1'b0;
      rand_upd();
      #1;
      checks++;
      if (q_count !== CNT_W'(2) || tbl_write !== 1'b1) begin
        errors++;
        $display("FAIL push_pop_count step=%0d q=%0d write=%b required 2 1", i, q_count, tbl_write);
      end
    end
    tick();
    upd_valid = 1'b0;
    repeat (QDEPTH + 2) tick();
  endtask

  task automatic test_forward();
    tick();
    fetch_req = 1'b1; fetch_idx = 10'h000;
    upd_valid = 1'b1; upd_idx = 10'h03A; upd_taken = 1'b1;
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_taken !== 1'b0) begin
      errors++;
      $display("FAIL fwd_empty hit=%b taken=%b required 0 0", fwd_hit, fwd_taken);
    end
    tick();
    fetch_idx = 10'h03A; upd_idx = 10'h03A; upd_taken = 1'b0;
    #1;
    checks++;
    if (fwd_hit !== FWD || fwd_taken !== FWD) begin
      errors++;
      $display("FAIL fwd_single hit=%b taken=%b required %b %b", fwd_hit, fwd_taken, FWD, FWD);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (fwd_hit !== FWD || fwd_taken !== 1'b0) begin
      errors++;
      $display("FAIL fwd_youngest hit=%b taken=%b required %b 0", fwd_hit, fwd_taken, FWD);
    end
    fetch_idx = 10'h03B;
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_taken !== 1'b0) begin
      errors++;
      $display("FAIL fwd_miss hit=%b taken=%b required 0 0", fwd_hit, fwd_taken);
    end
    tick();
    fetch_req = 1'b0;
    repeat (QDEPTH + 2) tick();
  endtask

  task automatic test_reset_mid_run();
    tick(); fetch_req = 1'b1; rand_upd();
    tick(); rand_upd();
    tick(); rand_upd();
    tick(); upd_valid = 1'b0;
    #1;
    checks++;
    if (q_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL pre_reset_count q=%0d required 3", q_count);
    end
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({init_busy, fetch_grant, upd_ready, tbl_read, tbl_write, tbl_wr_outcome, fwd_hit, fwd_taken}
        !== 8'b1000_0000 || tbl_idx !== '0 || tbl_wr_idx !== '0 || q_count !== '0) begin
      errors++;
      $display("FAIL midrun_reset flags=%b tbl_idx=%h wr_idx=%h q=%0d required 10000000 0 0 0",
               {init_busy, fetch_grant, upd_ready, tbl_read, tbl_write, tbl_wr_outcome, fwd_hit, fwd_taken},
               tbl_idx, tbl_wr_idx, q_count);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (tbl_write !== 1'b1 || tbl_wr_idx !== '0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_restart write=%b idx=%h busy=%b required 1 0 1", tbl_write, tbl_wr_idx, init_busy);
    end
    tick();
    checks++;
    if (tbl_wr_idx !== 10'h001) begin
      errors++;
      $display("FAIL sweep_step idx=%h required 001", tbl_wr_idx);
    end
    for (int i = 0; i < 1100 && init_busy === 1'b1; i++) tick();
    checks++;
    if (init_busy !== 1'b0 || upd_ready !== 1'b1 || q_count !== '0) begin
      errors++;
      $display("FAIL resweep_done busy=%b ready=%b q=%0d required 0 1 0", init_busy, upd_ready, q_count);
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_fetch_read();
    test_queue_full();
    test_push_pop();
    test_forward();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
